state_countdown: RTL and testbench

- Countdown stage of the timer; `stateID` = 2 in the top-level state machine.
- Sits directly downstream of the programming stage.
- On entering its state, loads the programmed {min, sec} value and counts it down once per second to 00:00.
- Supports pause/resume via `toggle`, drives the display bus, and raises `finished` for the alarm stage.

---
 rtl/state_countdown.sv | 159 +++++++++++++++
 tb/tb_state_countdown.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/state_countdown.sv
//------------------------------------------------------------------------------
// Module   : state_countdown
// Purpose  : Countdown stage of the timer. It loads {min, sec} when its state
//            is entered, then counts down once per second to 00:00, with
//            pause/resume and a held finished flag.
// Options  : STATE_COUNTDOWN_BCD_OUT_EN - drive digitsOut as packed BCD
//            instead of raw binary.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module state_countdown #(
    parameter logic [2:0] stateID       = 3'd2,
    parameter int         TICKS_PER_SEC = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  currentState,
    input  logic        toggle,
    input  logic [15:0] loadValue,
    output logic [15:0] digitsOut,
    output logic        running,
    output logic        finished
);

    localparam int c_PS_W = ($clog2(TICKS_PER_SEC) < 1) ? 1 : $clog2(TICKS_PER_SEC);
    localparam logic [c_PS_W-1:0] c_TICK_LAST = c_PS_W'(TICKS_PER_SEC - 1);
    localparam logic [7:0]        c_FIELD_MAX = 8'd59;

    logic [2:0]        r_prev_state;
    logic [7:0]        r_min;
    logic [7:0]        r_sec;
    logic [c_PS_W-1:0] r_prescaler;
    logic              r_running;
    logic              r_finished;

    logic              w_active;
    logic              w_entry;
    logic [7:0]        w_load_min;
    logic [7:0]        w_load_sec;
    logic              w_tick;
    logic [7:0]        w_dec_min;
    logic [7:0]        w_dec_sec;

    logic [7:0]        w_nxt_min;
    logic [7:0]        w_nxt_sec;
    logic [c_PS_W-1:0] w_nxt_prescaler;
    logic              w_nxt_running;
    logic              w_nxt_finished;

    assign w_active = (currentState == stateID);
    assign w_entry  = w_active && (r_prev_state != stateID);

    assign w_load_min = (loadValue[15:8] > c_FIELD_MAX) ? c_FIELD_MAX : loadValue[15:8];
    assign w_load_sec = (loadValue[7:0]  > c_FIELD_MAX) ? c_FIELD_MAX : loadValue[7:0];

    assign w_tick = w_active && !w_entry && r_running && (r_prescaler == c_TICK_LAST);

    // Borrow from minutes when seconds are exhausted; 00:00 never underflows.
    always_comb begin
        w_dec_min = r_min;
        w_dec_sec = r_sec;
        if (r_sec != 8'd0) begin
            w_dec_sec = r_sec - 8'd1;
        end else if (r_min != 8'd0) begin
            w_dec_min = r_min - 8'd1;
            w_dec_sec = c_FIELD_MAX;
        end
    end

    always_comb begin
        w_nxt_min       = r_min;
        w_nxt_sec       = r_sec;
        w_nxt_prescaler = r_prescaler;
        w_nxt_running   = r_running;
        w_nxt_finished  = r_finished;

        if (w_entry) begin
            w_nxt_min       = w_load_min;
            w_nxt_sec       = w_load_sec;
            w_nxt_prescaler = '0;
            if ((w_load_min == 8'd0) && (w_load_sec == 8'd0)) begin
                w_nxt_finished = 1'b1;
                w_nxt_running  = 1'b0;
            end else begin
                w_nxt_finished = 1'b0;
                w_nxt_running  = 1'b1;
            end
        end else if (w_active) begin
            if (r_running) begin
                w_nxt_prescaler = w_tick ? '0 : (r_prescaler + c_PS_W'(1));
            end
            if (toggle && !r_finished) begin
                w_nxt_running = ~r_running;
            end
            // Reaching zero overrides any toggle landing on the same edge.
            if (w_tick) begin
                w_nxt_min = w_dec_min;
                w_nxt_sec = w_dec_sec;
                if ((w_dec_min == 8'd0) && (w_dec_sec == 8'd0)) begin
                    w_nxt_finished = 1'b1;
                    w_nxt_running  = 1'b0;
                end
            end
        end else begin
            w_nxt_running = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_state <= 3'd0;
            r_min        <= 8'd0;
            r_sec        <= 8'd0;
            r_prescaler  <= '0;
            r_running    <= 1'b0;
            r_finished   <= 1'b0;
        end else begin
            r_prev_state <= currentState;
            r_min        <= w_nxt_min;
            r_sec        <= w_nxt_sec;
            r_prescaler  <= w_nxt_prescaler;
            r_running    <= w_nxt_running;
            r_finished   <= w_nxt_finished;
        end
    end

    assign running  = r_running;
    assign finished = r_finished;

`ifdef STATE_COUNTDOWN_BCD_OUT_EN
    // Fields never exceed 59, so a compare ladder for the tens digit suffices.
    function automatic logic [7:0] to_bcd(input logic [7:0] v);
        logic [3:0] tens;
        logic [7:0] rem;
        if (v >= 8'd50) begin
            tens = 4'd5; rem = v - 8'd50;
        end else if (v >= 8'd40) begin
            tens = 4'd4; rem = v - 8'd40;
        end else if (v >= 8'd30) begin
            tens = 4'd3; rem = v - 8'd30;
        end else if (v >= 8'd20) begin
            tens = 4'd2; rem = v - 8'd20;
        end else if (v >= 8'd10) begin
            tens = 4'd1; rem = v - 8'd10;
        end else begin
            tens = 4'd0; rem = v;
        end
        return {tens, rem[3:0]};
    endfunction

    assign digitsOut = {to_bcd(r_min), to_bcd(r_sec)};
`else
    assign digitsOut = {r_min, r_sec};
`endif

endmodule

`default_nettype wire

// File: tb/tb_state_countdown.sv
//------------------------------------------------------------------------------
// Module   : tb_state_countdown
// Purpose  : Directed, table-driven bench for state_countdown (TICKS_PER_SEC=4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_state_countdown;

    logic        clk;
    logic        rst_n;
    logic [2:0]  currentState;
    logic        toggle;
    logic [15:0] loadValue;
    logic [15:0] digitsOut;
    logic        running;
    logic        finished;

    int checks = 0;
    int errors = 0;

    state_countdown #(
        .stateID      (3'd2),
        .TICKS_PER_SEC(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .currentState(currentState),
        .toggle      (toggle),
        .loadValue   (loadValue),
        .digitsOut   (digitsOut),
        .running     (running),
        .finished    (finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  st;
        logic        tg;
        logic [15:0] ld;
        int          em;
        int          es;
        logic        er;
        logic        ef;
    } vec_t;

    vec_t tv[25];

    function automatic logic [15:0] fmt(input int m, input int s);
`ifdef STATE_COUNTDOWN_BCD_OUT_EN
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
`else
        return {8'(m), 8'(s)};
`endif
    endfunction

    task automatic check(input string name, input int m, input int s,
                         input logic er, input logic ef);
        logic [15:0] ed;
        ed = fmt(m, s);
        checks++;
        if (digitsOut !== ed || running !== er || finished !== ef) begin
            errors++;
            $display("FAIL %s: got digits=%h running=%b finished=%b, expected digits=%h running=%b finished=%b",
                     name, digitsOut, running, finished, ed, er, ef);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Cycle-by-cycle vectors: inputs applied before an edge, outputs checked after it.
        tv[0]  = '{3'd1, 1'b0, 16'h0002,  0,  0, 1'b0, 1'b0};
        tv[1]  = '{3'd2, 1'b0, 16'h0002,  0,  2, 1'b1, 1'b0};
        tv[2]  = '{3'd2, 1'b0, 16'h0002,  0,  2, 1'b1, 1'b0};
        tv[3]  = '{3'd2, 1'b0, 16'h0002,  0,  2, 1'b1, 1'b0};
        tv[4]  = '{3'd2, 1'b0, 16'h0002,  0,  2, 1'b1, 1'b0};
        tv[5]  = '{3'd2, 1'b0, 16'h0002,  0,  1, 1'b1, 1'b0};
        tv[6]  = '{3'd2, 1'b0, 16'h0002,  0,  1, 1'b1, 1'b0};
        tv[7]  = '{3'd2, 1'b0, 16'h0002,  0,  1, 1'b1, 1'b0};
        tv[8]  = '{3'd2, 1'b0, 16'h0002,  0,  1, 1'b1, 1'b0};
        tv[9]  = '{3'd2, 1'b0, 16'h0002,  0,  0, 1'b0, 1'b1};
        tv[10] = '{3'd2, 1'b1, 16'h0002,  0,  0, 1'b0, 1'b1};
        tv[11] = '{3'd1, 1'b0, 16'h0100,  0,  0, 1'b0, 1'b1};
        tv[12] = '{3'd2, 1'b0, 16'h0100,  1,  0, 1'b1, 1'b0};
        tv[13] = '{3'd2, 1'b0, 16'h0100,  1,  0, 1'b1, 1'b0};
        tv[14] = '{3'd2, 1'b0, 16'h0100,  1,  0, 1'b1, 1'b0};
        tv[15] = '{3'd2, 1'b0, 16'h0100,  1,  0, 1'b1, 1'b0};
        tv[16] = '{3'd2, 1'b0, 16'h0100,  0, 59, 1'b1, 1'b0};
        tv[17] = '{3'd1, 1'b0, 16'h0000,  0, 59, 1'b0, 1'b0};
        tv[18] = '{3'd2, 1'b0, 16'h0000,  0,  0, 1'b0, 1'b1};
        tv[19] = '{3'd1, 1'b0, 16'h4A4A,  0,  0, 1'b0, 1'b1};
        tv[20] = '{3'd2, 1'b0, 16'h4A4A, 59, 59, 1'b1, 1'b0};
        tv[21] = '{3'd2, 1'b1, 16'h0000, 59, 59, 1'b0, 1'b0};
        tv[22] = '{3'd1, 1'b0, 16'h0000, 59, 59, 1'b0, 1'b0};
        tv[23] = '{3'd2, 1'b1, 16'h0003,  0,  3, 1'b1, 1'b0};
        tv[24] = '{3'd3, 1'b0, 16'h0003,  0,  3, 1'b0, 1'b0};

        rst_n        = 1'b0;
        currentState = 3'd1;
        toggle       = 1'b0;
        loadValue    = 16'h0000;

        for (int i = 0; i < 3; i++) step();
        check("reset_held", 0, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        check("reset_released", 0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            currentState = tv[i].st;
            toggle       = tv[i].tg;
            loadValue    = tv[i].ld;
            step();
            check($sformatf("vec%0d", i), tv[i].em, tv[i].es, tv[i].er, tv[i].ef);
        end
        toggle = 1'b0;

        // Pause two cycles after entry, hold 20 cycles, resume; decrement lands 2 cycles later.
        currentState = 3'd1; loadValue = 16'h0005;
        step();
        currentState = 3'd2;
        step();
        check("pause_entry", 0, 5, 1'b1, 1'b0);
        step();
        toggle = 1'b1;
        step();
        toggle = 1'b0;
        check("pause_stop", 0, 5, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("pause_hold%0d", i), 0, 5, 1'b0, 1'b0);
        end
        toggle = 1'b1;
        step();
        toggle = 1'b0;
        check("resume_edge", 0, 5, 1'b1, 1'b0);
        step();
        check("resume_plus1", 0, 5, 1'b1, 1'b0);
        step();
        check("resume_plus2", 0, 4, 1'b1, 1'b0);

        // Leave mid-count, toggle while inactive, then re-enter with a new value.
        currentState = 3'd1;
        step();
        loadValue = 16'h0003;
        currentState = 3'd2;
        step();
        check("leave_entry", 0, 3, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step();
        check("leave_dec", 0, 2, 1'b1, 1'b0);
        currentState = 3'd1;
        toggle = 1'b1;
        step();
        check("leave_inactive", 0, 2, 1'b0, 1'b0);
        toggle = 1'b0;
        loadValue = 16'h0007;
        for (int i = 0; i < 6; i++) step();
        check("leave_hold", 0, 2, 1'b0, 1'b0);
        currentState = 3'd2;
        step();
        check("reenter_reload", 0, 7, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a cycle.
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 0, 0, 1'b0, 1'b0);
        #3;
        rst_n = 1'b1;
        currentState = 3'd1;
        step();
        check("post_reset_idle", 0, 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
